prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// UART-fed program loader: receives a framed, checksummed program image
// and writes it word by word into program memory, holding the CPU in reset.
module prog_loader #(
   parameter int          CLKS_PER_BIT = 16,
   parameter logic [7:0]  SYNC         = 8'hA5
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       RXD,
   output logic       WE,
   output logic [7:0] WADDR,
   output logic [9:0] WDATA,
   output logic       CPU_nRESET,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   localparam int            CW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [1:0] U_IDLE  = 2'd0;
   localparam logic [1:0] U_START = 2'd1;
   localparam logic [1:0] U_DATA  = 2'd2;
   localparam logic [1:0] U_STOP  = 2'd3;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_HI   = 3'd2;
   localparam logic [2:0] S_LO   = 3'd3;
   localparam logic [2:0] S_CSUM = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

   logic          r_rx_meta, r_rx_sync, r_rx_prev;
   logic [1:0]    r_ustate;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_bv, r_ferr;

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [8:0]    r_left;
   logic [7:0]    r_sum;
   logic [7:0]    w_sum_nxt;
   logic          w_idle_like;
   logic          r_we, r_cpu, r_busy, r_done, r_err;
   logic [7:0]    r_waddr;
   logic [9:0]    r_wdata;

   // two-flop synchronizer plus previous sample for edge detection
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= RXD;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // UART 8N1 receiver producing byte_valid / framing-error pulses
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_ustate <= U_IDLE;
         r_cnt    <= '0;
         r_bit    <= 3'd0;
         r_shift  <= 8'd0;
         r_bv     <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_bv   <= 1'b0;
         r_ferr <= 1'b0;
         unique case (r_ustate)
            U_IDLE: begin
               if (r_rx_prev && !r_rx_sync) begin
                  r_ustate <= U_START;
                  r_cnt    <= C_HALF;
               end
            end
            U_START: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (!r_rx_sync) begin
                  r_ustate <= U_DATA;
                  r_cnt    <= C_FULL;
                  r_bit    <= 3'd0;
               end else begin
                  r_ustate <= U_IDLE;
               end
            end
            U_DATA: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_shift <= {r_rx_sync, r_shift[7:1]};
                  r_cnt   <= C_FULL;
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) r_ustate <= U_STOP;
               end
            end
            default: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_bv     <= r_rx_sync;
                  r_ferr   <= !r_rx_sync;
                  r_ustate <= U_IDLE;
               end
            end
         endcase
      end
   end

   assign w_sum_nxt   = r_sum + r_shift;
   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) ||
                        (r_state == S_ERR);

   // frame next-state: moves only on byte_valid or framing error
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (r_bv && r_shift == SYNC) w_next = S_LEN;
         end
         S_LEN: begin
            if (r_ferr)    w_next = S_ERR;
            else if (r_bv) w_next = S_HI;
         end
         S_HI: begin
            if (r_ferr)                          w_next = S_ERR;
            else if (r_bv && r_shift[7:2] != '0) w_next = S_ERR;
            else if (r_bv)                       w_next = S_LO;
         end
         S_LO: begin
            if (r_ferr)    w_next = S_ERR;
            else if (r_bv) w_next = (r_left == 9'd1) ? S_CSUM : S_HI;
         end
         S_CSUM: begin
            if (r_ferr)    w_next = S_ERR;
            else if (r_bv) w_next = (w_sum_nxt == 8'd0) ? S_DONE : S_ERR;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // frame state, registered status outputs and memory write datapath
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= S_IDLE;
         r_left  <= 9'd0;
         r_sum   <= 8'd0;
         r_we    <= 1'b0;
         r_waddr <= 8'd0;
         r_wdata <= 10'd0;
         r_cpu   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == S_LEN) || (w_next == S_HI) ||
                    (w_next == S_LO)  || (w_next == S_CSUM);
         r_done  <= (w_next == S_DONE);
         r_err   <= (w_next == S_ERR);
         r_cpu   <= (w_next == S_DONE);
         r_we    <= (r_state == S_LO) && r_bv;
         if (r_we) r_waddr <= r_waddr + 8'd1;
         if (w_idle_like && r_bv && r_shift == SYNC) begin
            r_waddr <= 8'd0;
            r_sum   <= 8'd0;
         end
         if (r_bv) begin
            unique case (r_state)
               S_LEN: begin
                  r_left <= (r_shift == 8'd0) ? 9'd256 : {1'b0, r_shift};
                  r_sum  <= w_sum_nxt;
               end
               S_HI: begin
                  r_wdata[9:8] <= r_shift[1:0];
                  r_sum        <= w_sum_nxt;
               end
               S_LO: begin
                  r_wdata[7:0] <= r_shift;
                  r_sum        <= w_sum_nxt;
                  r_left       <= r_left - 9'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign WE         = r_we;
   assign WADDR      = r_waddr;
   assign WDATA      = r_wdata;
   assign CPU_nRESET = r_cpu;
   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign ERR        = r_err;

endmodule
